ezg_arbiter: RTL and testbench
==============================

EZG_ARBITER -- requirements
Module: ezg_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 19, the width of each requester sample.
REQ-002 SHALL have parameter LENGTH_LOG, default 6, the width of the code-length field.
REQ-003 SHALL have parameter TAG_DEPTH_LOG, default 2; the tag FIFO holds 2^TAG_DEPTH_LOG entries.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-005 SHALL have rst  in  1  asynchronous active-high reset.
REQ-006 SHALL have in0_data  in  DATA_WIDTH, in0_valid  in  1, in0_ready  out  1: requester 0 sample stream.
REQ-007 SHALL have in1_data  in  DATA_WIDTH, in1_valid  in  1, in1_ready  out  1: requester 1 sample stream.
REQ-008 SHALL have coder_in_data  out  DATA_WIDTH, coder_in_valid  out  1, coder_in_ready  in  1: feed to the shared exp-zero-Golomb coder.
REQ-009 SHALL have coder_out_code  in  2*DATA_WIDTH+1, coder_out_length  in  LENGTH_LOG, coder_out_valid  in  1, coder_out_ready  out  1: coder result stream.
REQ-010 SHALL have out0_code  out  2*DATA_WIDTH+1, out0_length  out  LENGTH_LOG, out0_valid  out  1, out0_ready  in  1: results for requester 0.
REQ-011 SHALL have out1_code, out1_length, out1_valid, out1_ready with the same widths/directions: results for requester 1.
REQ-012 SHALL have idle  out  1: high when tag FIFO empty and no input valid.

Function
REQ-013 SHALL use AXI-stream semantics on every port: transfer when valid and ready are high at a rising clk edge.
REQ-014 SHALL arbitrate round-robin: register last_grant; when not locked, grant the requester other than last_grant if valid, else last_grant if valid, else none.
REQ-015 SHALL lock the grant (register hold) when coder_in_valid high and coder_in_ready low; hold clears on the coder input transfer; data and grant stay stable while locked.
REQ-016 SHALL update last_grant to the granted index only on a coder input transfer.
REQ-017 SHALL drive coder_in_valid = granted input valid and tag FIFO not full; coder_in_data = granted input data (0 when no grant).
REQ-018 SHALL drive in<g>_ready = coder_in_ready and not full for the granted g; the non-granted ready SHALL be 0.
REQ-019 SHALL push the granted index into the tag FIFO on each coder input transfer; full blocks push even if a pop occurs in the same cycle.
REQ-020 SHALL select the route tag as FIFO head when non-empty, else the current grant (bypass for a zero-latency coder); no combinational path from coder_in_ready to any valid.
REQ-021 SHALL drive out<t>_valid = coder_out_valid, out<t>_code/length = coder result for route tag t; the other output's valid SHALL be 0.
REQ-022 SHALL drive coder_out_ready = out<t>_ready; pop the FIFO head on a coder output transfer when non-empty.
REQ-023 SHALL pop and push in the same cycle when FIFO non-full and non-empty, keeping occupancy unchanged; pointers wrap modulo 2^TAG_DEPTH_LOG; occupancy counter is TAG_DEPTH_LOG+1 bits.
REQ-024 SHALL, when FIFO empty and coder input and output transfer in the same cycle (bypass), neither push nor pop.
REQ-025 SHALL preserve per-requester ordering and never reorder results across requesters.

Reset
REQ-026 SHALL on rst: FIFO empty (pointers and count 0), hold 0, last_grant 1 (requester 0 wins first tie).
REQ-027 SHALL during/after reset drive in0_ready, in1_ready, coder_in_valid, out0_valid, out1_valid 0 (combinationally, given inputs low) and idle 1.
REQ-028 SHALL abandon all in-flight tags on reset mid-operation; the coder is reset by the same rst.

Verification
REQ-029 SHALL cover: both inputs valid continuously, in0={0,1,2}, in1={3,4,5}, zero-latency coder -> coder sees 0,3,1,4,2,5; out0 codes/lengths 1/1, 2/3, 3/3; out1 4/5, 5/5, 6/5.
REQ-030 SHALL cover: coder_in_ready held low 3 cycles with in1 valid and in0 asserting mid-stall -> grant stays 1, coder_in_data stable, in0 waits.
REQ-031 SHALL cover: 2-cycle-latency coder wrapper, out0_ready low -> FIFO fills to 4, coder_in_valid drops, both in_ready 0; releasing out0_ready drains in order.
REQ-032 SHALL cover: only in1 valid for 5 samples -> 5 consecutive grants to 1, all results on out1, out0_valid never high.
REQ-033 SHALL cover: rst asserted with 2 tags outstanding -> next cycle count 0, all valids 0, idle 1; first post-reset tie granted to requester 0.

Source files
------------

// File: rtl/ezg_arbiter.sv
// Round-robin front end that lets two sample streams share one exp-zero-Golomb coder.
// A small tag FIFO remembers which requester owns each code still inside the coder.
module ezg_arbiter #(
  parameter int DATA_WIDTH    = 19,
  parameter int LENGTH_LOG    = 6,
  parameter int TAG_DEPTH_LOG = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATA_WIDTH-1:0]   in0_data,
  input  logic                    in0_valid,
  output logic                    in0_ready,
  input  logic [DATA_WIDTH-1:0]   in1_data,
  input  logic                    in1_valid,
  output logic                    in1_ready,
  output logic [DATA_WIDTH-1:0]   coder_in_data,
  output logic                    coder_in_valid,
  input  logic                    coder_in_ready,
  input  logic [2*DATA_WIDTH:0]   coder_out_code,
  input  logic [LENGTH_LOG-1:0]   coder_out_length,
  input  logic                    coder_out_valid,
  output logic                    coder_out_ready,
  output logic [2*DATA_WIDTH:0]   out0_code,
  output logic [LENGTH_LOG-1:0]   out0_length,
  output logic                    out0_valid,
  input  logic                    out0_ready,
  output logic [2*DATA_WIDTH:0]   out1_code,
  output logic [LENGTH_LOG-1:0]   out1_length,
  output logic                    out1_valid,
  input  logic                    out1_ready,
  output logic                    idle
);
  localparam int TagDepth = 1 << TAG_DEPTH_LOG;

  logic                     lastGrant_q, lastGrant_d;
  logic                     hold_q, hold_d;
  logic                     holdGrant_q, holdGrant_d;
  logic [TagDepth-1:0]      tagMem_q, tagMem_d;
  logic [TAG_DEPTH_LOG-1:0] wrPtr_q, wrPtr_d;
  logic [TAG_DEPTH_LOG-1:0] rdPtr_q, rdPtr_d;
  logic [TAG_DEPTH_LOG:0]   count_q, count_d;

  logic grantValid, grant, grantInValid;
  logic fifoFull, fifoEmpty, routeTag;
  logic inXfer, outXfer, push, pop;

  // A stalled coder handshake pins the grant so the offered sample cannot change under it.
  always_comb begin
    grantValid = 1'b0;
    grant      = lastGrant_q;
    if (hold_q) begin
      grantValid = 1'b1;
      grant      = holdGrant_q;
    end else if (lastGrant_q ? in0_valid : in1_valid) begin
      grantValid = 1'b1;
      grant      = ~lastGrant_q;
    end else if (lastGrant_q ? in1_valid : in0_valid) begin
      grantValid = 1'b1;
      grant      = lastGrant_q;
    end
  end

  // Occupancy can only reach TagDepth, so its MSB alone signals full.
  assign fifoFull     = count_q[TAG_DEPTH_LOG];
  assign fifoEmpty    = (count_q == '0);
  assign grantInValid = grantValid & (grant ? in1_valid : in0_valid);

  assign coder_in_valid = grantInValid & ~fifoFull;
  assign coder_in_data  = !grantValid ? '0 : (grant ? in1_data : in0_data);
  assign in0_ready      = grantValid & ~grant & coder_in_ready & ~fifoFull;
  assign in1_ready      = grantValid &  grant & coder_in_ready & ~fifoFull;

  // With nothing in flight the result can only belong to the current grant.
  assign routeTag        = fifoEmpty ? grant : tagMem_q[rdPtr_q];
  assign coder_out_ready = routeTag ? out1_ready : out0_ready;
  assign out0_valid      = coder_out_valid & ~routeTag;
  assign out1_valid      = coder_out_valid &  routeTag;
  assign out0_code       = routeTag ? '0 : coder_out_code;
  assign out0_length     = routeTag ? '0 : coder_out_length;
  assign out1_code       = routeTag ? coder_out_code   : '0;
  assign out1_length     = routeTag ? coder_out_length : '0;

  assign idle = fifoEmpty & ~in0_valid & ~in1_valid;

  assign inXfer  = coder_in_valid & coder_in_ready;
  assign outXfer = coder_out_valid & coder_out_ready;
  assign push    = inXfer & ~fifoFull & ~(fifoEmpty & outXfer);
  assign pop     = outXfer & ~fifoEmpty;

  always_comb begin
    lastGrant_d = inXfer ? grant : lastGrant_q;
    hold_d      = coder_in_valid & ~coder_in_ready;
    holdGrant_d = grant;
    tagMem_d    = tagMem_q;
    wrPtr_d     = wrPtr_q;
    rdPtr_d     = rdPtr_q;
    count_d     = count_q;
    if (push) begin
      tagMem_d[wrPtr_q] = grant;
      wrPtr_d           = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d = rdPtr_q + 1'b1;
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lastGrant_q <= 1'b1;
      hold_q      <= 1'b0;
      holdGrant_q <= 1'b0;
      tagMem_q    <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      count_q     <= '0;
    end else begin
      lastGrant_q <= lastGrant_d;
      hold_q      <= hold_d;
      holdGrant_q <= holdGrant_d;
      tagMem_q    <= tagMem_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      count_q     <= count_d;
    end
  end

endmodule

// File: tb/tb_ezg_arbiter.sv
// Bench for ezg_arbiter: a behavioural exp-Golomb coder (zero or two-cycle latency)
// plus per-output scoreboards fed when samples are queued for the requesters.
module tb_ezg_arbiter;
  localparam int DW = 19;
  localparam int LW = 6;
  localparam int CW = 2*DW+1;

  logic clk = 1'b0;
  logic rst;
  logic [DW-1:0] in0_data, in1_data, coder_in_data;
  logic in0_valid, in0_ready, in1_valid, in1_ready;
  logic coder_in_valid, coder_in_ready;
  logic [CW-1:0] coder_out_code, out0_code, out1_code;
  logic [LW-1:0] coder_out_length, out0_length, out1_length;
  logic coder_out_valid, coder_out_ready;
  logic out0_valid, out0_ready, out1_valid, out1_ready;
  logic idle;

  int vectors = 0;
  int miscompares = 0;

  logic [DW-1:0]    src0[$], src1[$], expCoder[$];
  logic [CW+LW-1:0] exp0[$], exp1[$];
  logic en0 = 1'b1, en1 = 1'b1;
  logic fire0 = 1'b0, fire1 = 1'b0;
  logic latMode = 1'b0, coderStall = 1'b0, sawOut0 = 1'b0;
  int cinFires = 0, in1Grants = 0;

  logic [DW-1:0] cMem [8];
  int cRdy [8];
  int cHead = 0, cTail = 0, cCnt = 0, cyc = 0;
  logic [DW-1:0] coderSrc;
  logic [DW-1:0] monData;
  logic [CW+LW-1:0] monRes;

  always #5 clk = ~clk;

  ezg_arbiter #(.DATA_WIDTH(DW), .LENGTH_LOG(LW), .TAG_DEPTH_LOG(2)) dut (
    .clk(clk), .rst(rst),
    .in0_data(in0_data), .in0_valid(in0_valid), .in0_ready(in0_ready),
    .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
    .coder_in_data(coder_in_data), .coder_in_valid(coder_in_valid), .coder_in_ready(coder_in_ready),
    .coder_out_code(coder_out_code), .coder_out_length(coder_out_length),
    .coder_out_valid(coder_out_valid), .coder_out_ready(coder_out_ready),
    .out0_code(out0_code), .out0_length(out0_length), .out0_valid(out0_valid), .out0_ready(out0_ready),
    .out1_code(out1_code), .out1_length(out1_length), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .idle(idle)
  );

  function automatic logic [CW-1:0] egCode(input logic [DW-1:0] x);
    return CW'(x) + CW'(1);
  endfunction

  function automatic logic [LW-1:0] egLen(input logic [DW-1:0] x);
    logic [DW:0] n;
    int l;
    n = {1'b0, x} + 1'b1;
    l = 0;
    for (int i = 0; i < DW + 1; i++) begin
      if (n > 1) begin
        n = n >> 1;
        l++;
      end
    end
    return LW'(2*l + 1);
  endfunction

  // Behavioural coder: combinational pass-through, or an elastic two-cycle pipeline.
  assign coderSrc         = latMode ? cMem[cHead] : coder_in_data;
  assign coder_out_code   = egCode(coderSrc);
  assign coder_out_length = egLen(coderSrc);
  assign coder_out_valid  = latMode ? (cCnt != 0 && cyc >= cRdy[cHead]) : (coder_in_valid && !coderStall);
  assign coder_in_ready   = latMode ? (!coderStall && cCnt < 8) : (coder_out_ready && !coderStall);

  initial begin
    for (int i = 0; i < 8; i++) begin
      cMem[i] = '0;
      cRdy[i] = 0;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cHead <= 0;
      cTail <= 0;
      cCnt  <= 0;
    end else if (latMode) begin
      if (coder_in_valid && coder_in_ready) begin
        cMem[cTail] <= coder_in_data;
        cRdy[cTail] <= cyc + 2;
        cTail       <= (cTail + 1) % 8;
      end
      if (coder_out_valid && coder_out_ready) cHead <= (cHead + 1) % 8;
      cCnt <= cCnt + ((coder_in_valid && coder_in_ready) ? 1 : 0)
                   - ((coder_out_valid && coder_out_ready) ? 1 : 0);
    end
  end

  // Scoreboard: handshakes seen at the falling edge complete on the next rising edge.
  always @(negedge clk) begin
    fire0 = in0_valid && in0_ready;
    fire1 = in1_valid && in1_ready;
    if (!rst) begin
      if (coder_in_valid && coder_in_ready) begin
        cinFires++;
        if (in1_ready) in1Grants++;
        if (expCoder.size() != 0) begin
          monData = expCoder.pop_front();
          vectors++;
          if (coder_in_data !== monData) begin
            $display("[TB] FAIL coder_order: got %0d expected %0d", coder_in_data, monData);
            miscompares++;
          end
        end
      end
      if (out0_valid) sawOut0 = 1'b1;
      if (out0_valid && out0_ready) begin
        vectors++;
        if (exp0.size() == 0) begin
          $display("[TB] FAIL out0_unexpected: got code %0d len %0d expected no result", out0_code, out0_length);
          miscompares++;
        end else begin
          monRes = exp0.pop_front();
          if ({out0_code, out0_length} !== monRes) begin
            $display("[TB] FAIL out0_result: got code %0d len %0d expected code %0d len %0d",
                     out0_code, out0_length, monRes[CW+LW-1:LW], monRes[LW-1:0]);
            miscompares++;
          end
        end
      end
      if (out1_valid && out1_ready) begin
        vectors++;
        if (exp1.size() == 0) begin
          $display("[TB] FAIL out1_unexpected: got code %0d len %0d expected no result", out1_code, out1_length);
          miscompares++;
        end else begin
          monRes = exp1.pop_front();
          if ({out1_code, out1_length} !== monRes) begin
            $display("[TB] FAIL out1_result: got code %0d len %0d expected code %0d len %0d",
                     out1_code, out1_length, monRes[CW+LW-1:LW], monRes[LW-1:0]);
            miscompares++;
          end
        end
      end
    end
  end

  task automatic drive();
    in0_valid = en0 && (src0.size() != 0);
    in0_data  = (src0.size() != 0) ? src0[0] : '0;
    in1_valid = en1 && (src1.size() != 0);
    in1_data  = (src1.size() != 0) ? src1[0] : '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (fire0 && src0.size() != 0) void'(src0.pop_front());
    if (fire1 && src1.size() != 0) void'(src1.pop_front());
    drive();
  endtask

  task automatic queue0(input logic [DW-1:0] d);
    src0.push_back(d);
    exp0.push_back({egCode(d), egLen(d)});
  endtask

  task automatic queue1(input logic [DW-1:0] d);
    src1.push_back(d);
    exp1.push_back({egCode(d), egLen(d)});
  endtask

  task automatic drain(input int budget, input string name);
    int pending;
    for (int i = 0; i < budget; i++) begin
      pending = src0.size() + src1.size() + exp0.size() + exp1.size() + expCoder.size();
      if (pending == 0) break;
      step();
    end
    pending = src0.size() + src1.size() + exp0.size() + exp1.size() + expCoder.size();
    vectors++;
    if (pending != 0) begin
      $display("[TB] FAIL %s_timeout: %0d items pending expected 0", name, pending);
      miscompares++;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors += 4;
    if ({in0_ready, in1_ready} !== 2'b00) begin
      $display("[TB] FAIL reset_in_ready: got %b expected 00", {in0_ready, in1_ready}); miscompares++;
    end
    if (coder_in_valid !== 1'b0) begin
      $display("[TB] FAIL reset_coder_valid: got %b expected 0", coder_in_valid); miscompares++;
    end
    if ({out0_valid, out1_valid} !== 2'b00) begin
      $display("[TB] FAIL reset_out_valid: got %b expected 00", {out0_valid, out1_valid}); miscompares++;
    end
    if (idle !== 1'b1) begin
      $display("[TB] FAIL reset_idle: got %b expected 1", idle); miscompares++;
    end
    step();
    rst = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [DW-1:0] order [6] = '{0, 3, 1, 4, 2, 5};
    $display("[TB] round robin, zero-latency coder");
    latMode = 1'b0;
    for (int i = 0; i < 6; i++) expCoder.push_back(order[i]);
    src0 = '{0, 1, 2};
    src1 = '{3, 4, 5};
    exp0 = '{{39'd1, 6'd1}, {39'd2, 6'd3}, {39'd3, 6'd3}};
    exp1 = '{{39'd4, 6'd5}, {39'd5, 6'd5}, {39'd6, 6'd5}};
    drive();
    drain(40, "round_robin");
  endtask

  task automatic test_stall();
    $display("[TB] coder stall holds grant");
    coderStall = 1'b1;
    en0 = 1'b0;
    queue1(7);
    queue0(8);
    expCoder.push_back(7);
    expCoder.push_back(8);
    drive();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors += 3;
      if ({coder_in_valid, coder_in_data} !== {1'b1, 19'd7}) begin
        $display("[TB] FAIL stall_data c%0d: got valid %b data %0d expected valid 1 data 7", c, coder_in_valid, coder_in_data);
        miscompares++;
      end
      if (in0_ready !== 1'b0) begin
        $display("[TB] FAIL stall_in0_ready c%0d: got %b expected 0", c, in0_ready); miscompares++;
      end
      if (in1_ready !== 1'b0) begin
        $display("[TB] FAIL stall_in1_ready c%0d: got %b expected 0", c, in1_ready); miscompares++;
      end
      if (c == 0) en0 = 1'b1;
      step();
    end
    coderStall = 1'b0;
    drain(40, "stall");
  endtask

  task automatic test_fifo_fill();
    $display("[TB] tag FIFO fill with two-cycle coder");
    latMode = 1'b1;
    out0_ready = 1'b0;
    cinFires = 0;
    for (int i = 0; i < 6; i++) queue0(DW'(10 + i));
    drive();
    for (int i = 0; i < 12; i++) step();
    @(negedge clk);
    vectors += 4;
    if (cinFires !== 4) begin
      $display("[TB] FAIL fill_accepted: got %0d expected 4", cinFires); miscompares++;
    end
    if (coder_in_valid !== 1'b0) begin
      $display("[TB] FAIL fill_coder_valid: got %b expected 0", coder_in_valid); miscompares++;
    end
    if ({in0_ready, in1_ready} !== 2'b00) begin
      $display("[TB] FAIL fill_in_ready: got %b expected 00", {in0_ready, in1_ready}); miscompares++;
    end
    if ({out0_valid, out1_valid} !== 2'b10) begin
      $display("[TB] FAIL fill_out_valid: got %b expected 10", {out0_valid, out1_valid}); miscompares++;
    end
    step();
    out0_ready = 1'b1;
    drain(60, "fifo_fill");
  endtask

  task automatic test_single_requester();
    $display("[TB] only requester 1 active");
    latMode = 1'b0;
    sawOut0 = 1'b0;
    cinFires = 0;
    in1Grants = 0;
    for (int i = 0; i < 5; i++) queue1(DW'(20 + i));
    drive();
    drain(40, "single");
    vectors += 2;
    if (in1Grants !== 5 || cinFires !== 5) begin
      $display("[TB] FAIL single_grants: got %0d of %0d expected 5 of 5", in1Grants, cinFires); miscompares++;
    end
    if (sawOut0 !== 1'b0) begin
      $display("[TB] FAIL single_out0_valid: got %b expected 0", sawOut0); miscompares++;
    end
  endtask

  task automatic test_back_to_back();
    $display("[TB] both requesters through two-cycle coder");
    latMode = 1'b1;
    for (int i = 0; i < 4; i++) begin
      queue0(DW'(30 + i));
      queue1(DW'(40 + i));
      expCoder.push_back(DW'(30 + i));
      expCoder.push_back(DW'(40 + i));
    end
    drive();
    drain(80, "back_to_back");
  endtask

  task automatic test_reset_midflight();
    $display("[TB] reset with tags outstanding");
    latMode = 1'b1;
    out0_ready = 1'b0;
    out1_ready = 1'b0;
    cinFires = 0;
    src0 = '{50, 51};
    drive();
    for (int i = 0; i < 20 && cinFires < 2; i++) step();
    @(negedge clk);
    vectors += 2;
    if (cinFires !== 2) begin
      $display("[TB] FAIL midflight_accepted: got %0d expected 2", cinFires); miscompares++;
    end
    if (idle !== 1'b0) begin
      $display("[TB] FAIL midflight_busy: got idle %b expected 0", idle); miscompares++;
    end
    step();
    rst = 1'b1;
    src0.delete();
    src1.delete();
    drive();
    @(negedge clk);
    vectors += 3;
    if (idle !== 1'b1) begin
      $display("[TB] FAIL midflight_idle: got %b expected 1", idle); miscompares++;
    end
    if ({coder_in_valid, out0_valid, out1_valid} !== 3'b000) begin
      $display("[TB] FAIL midflight_valids: got %b expected 000", {coder_in_valid, out0_valid, out1_valid}); miscompares++;
    end
    if ({in0_ready, in1_ready} !== 2'b00) begin
      $display("[TB] FAIL midflight_ready: got %b expected 00", {in0_ready, in1_ready}); miscompares++;
    end
    step();
    rst = 1'b0;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    queue0(60);
    queue1(70);
    expCoder.push_back(60);
    expCoder.push_back(70);
    drive();
    @(negedge clk);
    vectors++;
    if ({in0_ready, in1_ready} !== 2'b10) begin
      $display("[TB] FAIL post_reset_tie: got %b expected 10", {in0_ready, in1_ready}); miscompares++;
    end
    drain(40, "post_reset");
  endtask

  initial begin
    rst = 1'b1;
    out0_ready = 1'b1;
    out1_ready = 1'b1;
    drive();
    test_reset();
    test_round_robin();
    test_stall();
    test_fifo_fill();
    test_single_requester();
    test_back_to_back();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t expected finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
